// File: rtl/avg_pkg.sv
// avg_pkg: shared constants, counter widths and state encoding for sample_window_avg
package avg_pkg;
  localparam int DATAWIDTH = 16;
  localparam int SUMWIDTH = 32;
  localparam int NUM_SAMPLES = 8;
  localparam int NUM_SHIFTS = 3;
  localparam int SCNT_W = $clog2(NUM_SAMPLES);
  localparam int HCNT_W = $clog2(NUM_SHIFTS);
  typedef enum logic [1:0] {COLLECT, SHIFT, HOLD} state_t;
endpackage

// File: rtl/add.sv
// add: unsigned adder, result wraps at DATAWIDTH bits
module add #(
  parameter int DATAWIDTH = 16
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] y
);
  assign y = a + b;
endmodule

// File: rtl/avg_ctrl.sv
// avg_ctrl: window FSM with sample and shift counters, drives the datapath strobes
module avg_ctrl
  import avg_pkg::*;
(
  input  logic Clk,
  input  logic Rst_n,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic acc_load,
  output logic acc_shift,
  output logic acc_clr,
  output logic sa_latch,
  output logic avg_load
);
  state_t state_q, state_d;
  logic [SCNT_W-1:0] scnt;
  logic [HCNT_W-1:0] hcnt;
  logic accept;
  assign in_ready = Rst_n && state_q == COLLECT;
  assign out_valid = state_q == HOLD;
  // state register and the two counters
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= COLLECT;
      scnt <= '0;
      hcnt <= '0;
    end else begin
      state_q <= state_d;
      scnt <= acc_clr ? '0 : accept ? scnt + SCNT_W'(1) : scnt;
      hcnt <= sa_latch ? '0 : acc_shift ? hcnt + HCNT_W'(1) : hcnt;
    end
  end
  // datapath strobes and next-state decode
  always_comb begin
    state_d = state_q;
    accept = in_valid && state_q == COLLECT;
    acc_load = accept;
    sa_latch = accept && scnt == SCNT_W'(NUM_SAMPLES - 1);
    acc_shift = state_q == SHIFT;
    avg_load = acc_shift && hcnt == HCNT_W'(NUM_SHIFTS - 1);
    acc_clr = state_q == HOLD && out_ready;
    case (state_q)
      COLLECT: state_d = sa_latch ? SHIFT : COLLECT;
      SHIFT:   state_d = avg_load ? HOLD : SHIFT;
      HOLD:    state_d = acc_clr ? COLLECT : HOLD;
      default: state_d = COLLECT;
    endcase
  end
endmodule

// File: rtl/shr.sv
// shr: logical right shift; shift amounts of DATAWIDTH or more give zero
module shr #(
  parameter int DATAWIDTH = 16
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [7:0]           sh,
  output logic [DATAWIDTH-1:0] y
);
  assign y = a >> sh;
endmodule

// File: rtl/sample_window_avg.sv
// sample_window_avg: streaming 8-sample accumulator with three sequential right shifts
module sample_window_avg
  import avg_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           sa,
  output logic [DATAWIDTH-1:0] out_avg,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [SUMWIDTH-1:0] acc, sum, shifted;
  logic [7:0] sa_q;
  logic acc_load, acc_shift, acc_clr, sa_latch, avg_load;
  avg_ctrl u_ctrl (
    .Clk(Clk),
    .Rst_n(Rst_n),
    .in_valid(in_valid),
    .out_ready(out_ready),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .acc_load(acc_load),
    .acc_shift(acc_shift),
    .acc_clr(acc_clr),
    .sa_latch(sa_latch),
    .avg_load(avg_load)
  );
  add #(.DATAWIDTH(SUMWIDTH)) u_add (
    .a(acc),
    .b({{(SUMWIDTH-DATAWIDTH){1'b0}}, in_data}),
    .y(sum)
  );
  shr #(.DATAWIDTH(SUMWIDTH)) u_shr (
    .a(acc),
    .sh(sa_q),
    .y(shifted)
  );
  // accumulator, latched shift amount and the result register captured on the last shift
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc <= '0;
      sa_q <= '0;
      out_avg <= '0;
    end else begin
      acc <= acc_clr ? '0 : acc_load ? sum : acc_shift ? shifted : acc;
      sa_q <= sa_latch ? sa : sa_q;
      out_avg <= avg_load ? shifted[DATAWIDTH-1:0] : out_avg;
    end
  end
endmodule
